// File: rtl/control_adc_spi.sv
// control_adc_spi: derives ADC CS/SCLK frame timing and per-bit/per-frame strobes from clk.
// Define ADC_POWERDOWN_EN to add the ADC power-down (PDOWN) and wake-up (WAKE) frames.
module control_adc_spi #(
    parameter int HALF_SCLK  = 5,
    parameter int SAMPLE_DIV = 2268,
    parameter int QUIET      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       CS,
    output logic       SCLK,
    output logic       sclk_fall_tick,
    output logic [3:0] bit_idx,
    output logic       frame_start,
    output logic       frame_done,
    output logic       busy,
    output logic       powered_down
);
    // state    | meaning
    // ST_IDLE  | stopped, CS/SCLK high, sample counter held at 0
    // ST_WAIT  | CS high, sample counter running towards the next frame
    // ST_SETUP | CS low, SCLK high for the ADC setup time
    // ST_SHIFT | 16 SCLK periods with data-bit strobes
    // ST_QUIET | CS high gap after a frame
    // ST_PDOWN | 8 SCLK periods without strobes, puts the ADC in power-down
    // ST_WAKE  | 16 SCLK periods without strobes, wakes the ADC
`ifdef ADC_POWERDOWN_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_SETUP, ST_SHIFT, ST_QUIET, ST_PDOWN, ST_WAKE} state_t;
    typedef enum logic [1:0] {K_NORM, K_PDOWN, K_WAKE} kind_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_SETUP, ST_SHIFT, ST_QUIET} state_t;
`endif

    localparam int PMAX = (HALF_SCLK > QUIET) ? HALF_SCLK : QUIET;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int SW   = $clog2(SAMPLE_DIV + 1);
    localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_SCLK - 1);
    localparam logic [PW-1:0] QUIET_LOAD = PW'(QUIET - 1);
    localparam logic [SW-1:0] SMP_LOAD   = SW'(SAMPLE_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [SW-1:0] smp_q, smp_d;
    logic [3:0]    bit_q, bit_d;
    logic          low_q, low_d;
    logic          shifting, cs_d, sclk_d, busy_d, tick_d;
`ifdef ADC_POWERDOWN_EN
    kind_t         kind_q, kind_d;
    logic          pd_q, pd_d;
`endif

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        smp_d   = (smp_q == '0) ? '0 : smp_q - SW'(1);
        bit_d   = bit_q;
        low_d   = low_q;
`ifdef ADC_POWERDOWN_EN
        kind_d  = kind_q;
        pd_d    = pd_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                smp_d = '0;
                if (enable) begin
                    state_d = ST_SETUP;
                    ph_d    = HALF_LOAD;
                    smp_d   = SMP_LOAD;
`ifdef ADC_POWERDOWN_EN
                    kind_d  = pd_q ? K_WAKE : K_NORM;
`endif
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    smp_d   = '0;
                end else if (smp_q == '0) begin
                    state_d = ST_SETUP;
                    ph_d    = HALF_LOAD;
                    smp_d   = SMP_LOAD;
`ifdef ADC_POWERDOWN_EN
                    kind_d  = K_NORM;
`endif
                end
            end
            ST_SETUP: begin
                ph_d = ph_q - PW'(1);
                if (ph_q == '0) begin
                    ph_d    = HALF_LOAD;
                    low_d   = 1'b1;
                    bit_d   = 4'd15;
                    state_d = ST_SHIFT;
`ifdef ADC_POWERDOWN_EN
                    if (kind_q == K_PDOWN) begin
                        state_d = ST_PDOWN;
                        bit_d   = 4'd7;
                    end else if (kind_q == K_WAKE) begin
                        state_d = ST_WAKE;
                    end
`endif
                end
            end
            ST_QUIET: begin
                ph_d = ph_q - PW'(1);
                if (ph_q == '0) begin
`ifdef ADC_POWERDOWN_EN
                    if (kind_q == K_PDOWN) begin
                        state_d = ST_IDLE;
                        smp_d   = '0;
                        pd_d    = 1'b1;
                    end else if (enable) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_SETUP;
                        ph_d    = HALF_LOAD;
                        smp_d   = SMP_LOAD;
                        kind_d  = K_PDOWN;
                    end
`else
                    if (enable) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                        smp_d   = '0;
                    end
`endif
                end
            end
            default: begin
                // every SCLK-driving state: low half, then high half, last high half ends the frame
                ph_d = ph_q - PW'(1);
                if (ph_q == '0) begin
                    ph_d = HALF_LOAD;
                    if (low_q) begin
                        low_d = 1'b0;
                    end else if (bit_q == 4'd0) begin
                        state_d = ST_QUIET;
                        ph_d    = QUIET_LOAD;
`ifdef ADC_POWERDOWN_EN
                        if (state_q == ST_WAKE) pd_d = 1'b0;
`endif
                    end else begin
                        low_d = 1'b1;
                        bit_d = bit_q - 4'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
`ifdef ADC_POWERDOWN_EN
        shifting = (state_q == ST_SHIFT) || (state_q == ST_PDOWN) || (state_q == ST_WAKE);
`else
        shifting = (state_q == ST_SHIFT);
`endif
        cs_d   = !(shifting || (state_q == ST_SETUP));
        sclk_d = !(shifting && low_q);
        busy_d = !cs_d || (state_q == ST_QUIET);
        tick_d = SCLK && !sclk_d && (state_q == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            ph_q           <= '0;
            smp_q          <= '0;
            bit_q          <= '0;
            low_q          <= 1'b0;
            CS             <= 1'b1;
            SCLK           <= 1'b1;
            sclk_fall_tick <= 1'b0;
            bit_idx        <= '0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            ph_q           <= ph_d;
            smp_q          <= smp_d;
            bit_q          <= bit_d;
            low_q          <= low_d;
            CS             <= cs_d;
            SCLK           <= sclk_d;
            sclk_fall_tick <= tick_d;
            frame_start    <= CS && !cs_d;
            frame_done     <= !CS && cs_d;
            busy           <= busy_d;
            if (tick_d) bit_idx <= bit_q;
        end
    end

`ifdef ADC_POWERDOWN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind_q       <= K_NORM;
            pd_q         <= 1'b0;
            powered_down <= 1'b0;
        end else begin
            kind_q       <= kind_d;
            pd_q         <= pd_d;
            powered_down <= pd_q;
        end
    end
`else
    assign powered_down = 1'b0;
`endif
endmodule

// File: tb/tb_control_adc_spi.sv
// Self-checking bench for control_adc_spi: frame table, hand sequences and a random
// enable pattern compared every cycle against an event-time reference model.
module tb_control_adc_spi;
    localparam int H  = 5;
    localparam int QU = 10;
    localparam int SD = 2268;
    localparam longint FR = 33 * H;
    localparam logic [10:0] RESET_VEC = 11'b11_0_0000_000_0;

    logic clk = 1'b0;
    logic reset, enable;
    logic CS, SCLK, sclk_fall_tick, frame_start, frame_done, busy, powered_down;
    logic [3:0] bit_idx;

    int checks = 0;
    int failures = 0;
    longint cyc = 0;
    bit model_on = 1'b1;

    control_adc_spi #(.HALF_SCLK(H), .SAMPLE_DIV(SD), .QUIET(QU)) dut (
        .clk(clk), .reset(reset), .enable(enable), .CS(CS), .SCLK(SCLK),
        .sclk_fall_tick(sclk_fall_tick), .bit_idx(bit_idx), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy), .powered_down(powered_down)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: tracks frame start times E from the enable rules, derives outputs from t = n - E.
    bit          m_idle = 1'b1;
    longint      m_e = -1000000;
    longint      mn = 0;
    logic [3:0]  m_bit = 4'd0;
    logic [10:0] exp_vec = RESET_VEC;

    always @(posedge clk) begin
        longint t;
        logic e_cs, e_sclk, e_tick, e_fs, e_fd, e_busy;
        if (!reset) begin
            m_idle = 1'b1; m_e = -1000000; mn = 0; m_bit = 4'd0;
        end else begin
            mn = mn + 1;
            t = mn - m_e;
            if (m_idle) begin
                if (enable) begin m_idle = 1'b0; m_e = mn + 1; end
            end else if (t == FR + QU - 1) begin
                if (!enable) m_idle = 1'b1;
            end else if (t >= FR + QU) begin
                if (!enable) m_idle = 1'b1;
                else if (t == SD - 1) m_e = mn + 1;
            end
        end
        t      = mn - m_e;
        e_cs   = !(t >= 0 && t < FR);
        e_sclk = !(t >= H && t < FR && ((t - H) % (2 * H)) < H);
        e_tick = (t >= H && t < FR && ((t - H) % (2 * H)) == 0);
        if (e_tick) m_bit = 4'(15 - (t - H) / (2 * H));
        e_fs   = (t == 0);
        e_fd   = (t == FR);
        e_busy = (t >= 0 && t < FR + QU);
        exp_vec = {e_cs, e_sclk, e_tick, m_bit, e_fs, e_fd, e_busy, 1'b0};
    end

    always @(negedge clk) begin
        if (model_on)
            check("model", {21'd0, CS, SCLK, sclk_fall_tick, bit_idx, frame_start, frame_done, busy, powered_down},
                  {21'd0, (reset ? exp_vec : RESET_VEC)});
    end

    task automatic wait_fs(input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_start) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s: no frame_start within %0d clk", name, budget);
        end
    endtask

    task automatic measure_frame(input int budget, output longint e, output int nfall, output int nticks,
                                 output logic pd_pre, output logic pd_done, output bit ok);
        logic prev_s;
        nfall = 0; nticks = 0; pd_pre = 1'b0; pd_done = 1'b0; e = 0;
        wait_fs(budget, "measure start", ok);
        if (ok) begin
            e = cyc; prev_s = SCLK; ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                pd_pre = powered_down;
                @(negedge clk);
                if (prev_s && !SCLK) nfall++;
                if (sclk_fall_tick) nticks++;
                prev_s = SCLK;
                if (frame_done) begin pd_done = powered_down; ok = 1'b1; break; end
            end
            if (!ok) begin
                checks++; failures++;
                $display("FAIL measure done: no frame_done within 400 clk");
            end
        end
    endtask

    typedef struct {
        int         t;
        logic       en;
        logic       cs, sclk, tick;
        logic [3:0] bidx;
        logic       fs, fd, bsy;
    } vec_t;

    initial begin
        vec_t   tbl[19];
        longint e, e_prev, k0, tc, done_cyc;
        int     nf, nt, cnt, hold, total;
        logic   pp, pd;
        bit     ok;

        tbl[0]  = '{-1,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{0,   1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4,   1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[4]  = '{5,   1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{6,   1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{9,   1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{10,  1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{15,  1'b0, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{85,  1'b0, 1'b0, 1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b1};
        tbl[10] = '{155, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[11] = '{159, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[12] = '{160, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[13] = '{164, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[14] = '{165, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1};
        tbl[15] = '{166, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[16] = '{174, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[17] = '{175, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        tbl[18] = '{176, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};

        reset = 1'b0; enable = 1'b1;
`ifdef ADC_POWERDOWN_EN
        model_on = 1'b0;
`endif
        repeat (50) @(negedge clk);
        check("reset outputs", {21'd0, CS, SCLK, sclk_fall_tick, bit_idx, frame_start, frame_done, busy, powered_down},
              {21'd0, RESET_VEC});
`ifdef ADC_POWERDOWN_EN
        reset = 1'b1;
        measure_frame(50, e, nf, nt, pp, pd, ok);
        check("pd normal ticks", nt, 16);
        enable = 1'b0;
        e_prev = e;
        measure_frame(50, e, nf, nt, pp, pd, ok);
        check("pdown gap", 32'(e - e_prev), 175);
        check("pdown sclk falls", nf, 8);
        check("pdown ticks", nt, 0);
        repeat (QU + 2) @(negedge clk);
        check("powered_down set", powered_down, 1);
        check("busy after pdown", busy, 0);
        repeat (20) @(negedge clk);
        enable = 1'b1;
        measure_frame(50, e, nf, nt, pp, pd, ok);
        check("wake sclk falls", nf, 16);
        check("wake ticks", nt, 0);
        check("pd before wake done", pp, 1);
        check("pd at wake done", pd, 0);
        e_prev = e;
        measure_frame(2400, e, nf, nt, pp, pd, ok);
        check("first frame after wake", 32'(e - e_prev), SD);
        check("ticks after wake", nt, 16);
`else
        reset = 1'b1; enable = 1'b0;
        repeat (5) @(negedge clk);

        // single frame against the hand-derived table
        enable = 1'b1; k0 = cyc; e = k0 + 2;
        for (int i = 0; i < 19; i++) begin
            while (cyc < e + tbl[i].t) @(negedge clk);
            check($sformatf("table t=%0d", tbl[i].t),
                  {22'd0, CS, SCLK, sclk_fall_tick, bit_idx, frame_start, frame_done, busy},
                  {22'd0, tbl[i].cs, tbl[i].sclk, tbl[i].tick, tbl[i].bidx, tbl[i].fs, tbl[i].fd, tbl[i].bsy});
            enable = tbl[i].en;
        end
        repeat (10) @(negedge clk);

        // periodic frames
        enable = 1'b1; e_prev = 0;
        for (int f = 0; f < 6; f++) begin
            measure_frame(2400, e, nf, nt, pp, pd, ok);
            check($sformatf("periodic ticks f%0d", f), nt, 16);
            check($sformatf("periodic falls f%0d", f), nf, 16);
            if (f > 0) check($sformatf("periodic spacing f%0d", f), 32'(e - e_prev), SD);
            e_prev = e;
        end

        // drop enable after bit 7
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sclk_fall_tick && bit_idx == 4'd7) begin ok = 1'b1; break; end
        end
        check("bit7 tick seen", ok, 1);
        tc = cyc; enable = 1'b0; cnt = 0; done_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sclk_fall_tick) cnt++;
            if (frame_done) begin done_cyc = cyc; break; end
        end
        check("ticks after disable", cnt, 7);
        check("cs rise after disable", 32'(done_cyc - tc), 80);
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (frame_start) cnt++;
        end
        check("no frame while disabled", cnt, 0);
        check("busy idle", busy, 0);

        // re-enable inside QUIET keeps the sample grid
        enable = 1'b1; k0 = cyc;
        wait_fs(50, "idle start", ok);
        check("idle start latency", 32'(cyc - k0), 2);
        e = cyc; enable = 1'b0;
        while (cyc < e + 168) @(negedge clk);
        enable = 1'b1;
        wait_fs(3000, "quiet re-enable", ok);
        check("quiet re-enable spacing", 32'(cyc - e), SD);
        enable = 1'b0;
        repeat (2500) @(negedge clk);

        // random enable pattern, judged by the reference model
        total = 0;
        while (total < 30000) begin
            enable = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6000)) : int'($urandom_range(1, 300));
            repeat (hold) @(negedge clk);
            total += hold;
        end
        enable = 1'b0;
        repeat (2500) @(negedge clk);

        // asynchronous reset in the middle of SHIFT
        enable = 1'b1;
        wait_fs(50, "pre-reset start", ok);
        repeat (55) @(negedge clk);
        @(posedge clk);
        #1;
        check("pre-reset cs/sclk", {30'd0, CS, SCLK}, 0);
        #1 reset = 1'b0;
        #1;
        check("async reset", {26'd0, CS, SCLK, sclk_fall_tick, frame_start, frame_done, busy}, 32'b110000);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post-reset idle", {30'd0, CS, busy}, 2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
